// File: rtl/axonerve_kvs_rtl_lane_alu.sv
// Multi-lane AXI4-Stream ALU stage: per-lane op against a latched constant, with transfer start/busy/done control.
// Latency: C_PIPE_STAGES cycles from input accept to m_axis_tvalid when the output is not stalled.
// Backpressure: full valid/ready chain; a stage loads when it is empty or its successor is loading, so no beat is lost or repeated.
module axonerve_kvs_rtl_lane_alu #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 32,
    parameter int C_PIPE_STAGES      = 2
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            ctrl_start,
    input  logic [2:0]                      ctrl_mode,
    input  logic [C_LANE_WIDTH-1:0]         ctrl_constant,
    output logic                            ctrl_busy,
    output logic                            ctrl_done,
    output logic [31:0]                     ctrl_beat_count,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast
);

    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int KW = DW / 8;
    localparam int LW = C_LANE_WIDTH;
    localparam int NL = DW / LW;
    localparam int NS = C_PIPE_STAGES;

    // Parameter legality: stop elaboration on combinations the lane slicing cannot support.
    generate
        if ((C_AXIS_TDATA_WIDTH % C_LANE_WIDTH) != 0 || C_AXIS_TDATA_WIDTH < C_LANE_WIDTH) begin : g_err_width
            $error("C_AXIS_TDATA_WIDTH must be a non-zero multiple of C_LANE_WIDTH");
        end
        if ((C_LANE_WIDTH % 8) != 0 || C_LANE_WIDTH < 8 || C_LANE_WIDTH > 64) begin : g_err_lane
            $error("C_LANE_WIDTH must be a multiple of 8 in the range 8..64");
        end
        if (C_PIPE_STAGES < 1 || C_PIPE_STAGES > 4) begin : g_err_stages
            $error("C_PIPE_STAGES must be in the range 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_done_nxt;
    logic            r_done;
    logic [2:0]      r_mode;
    logic [LW-1:0]   r_const;
    logic [31:0]     r_beat_cnt;

    logic            w_in_acc;
    logic            w_out_acc;
    logic            w_start_acc;
    logic [NS-1:0]   w_stage_rdy;
    logic [DW-1:0]   w_lane_res;

    logic [NS-1:0]   r_vld;
    logic [NS-1:0]   r_last;
    logic [DW-1:0]   r_dat  [NS];
    logic [KW-1:0]   r_keep [NS];

    assign w_start_acc   = (r_state == ST_IDLE) && ctrl_start;
    assign s_axis_tready = (r_state == ST_RUN) && w_stage_rdy[0];
    assign w_in_acc      = s_axis_tvalid && s_axis_tready;
    assign w_out_acc     = m_axis_tvalid && m_axis_tready;

    assign m_axis_tvalid   = r_vld[NS-1];
    assign m_axis_tdata    = r_dat[NS-1];
    assign m_axis_tkeep    = r_keep[NS-1];
    assign m_axis_tlast    = r_last[NS-1];
    assign ctrl_busy       = (r_state != ST_IDLE);
    assign ctrl_done       = r_done;
    assign ctrl_beat_count = r_beat_cnt;

    // Stage k may load when any stage from k to the output is empty, or the sink is taking a beat.
    always_comb begin
        logic v_full;
        w_stage_rdy = '0;
        v_full      = 1'b1;
        for (int k = 0; k < NS; k++) begin
            v_full = 1'b1;
            for (int j = k; j < NS; j++) begin
                v_full = v_full & r_vld[j];
            end
            w_stage_rdy[k] = m_axis_tready | ~v_full;
        end
    end

    // Per-lane unsigned arithmetic on the incoming beat, feeding stage 1.
    generate
        for (genvar l = 0; l < NL; l++) begin : g_lane
            logic [LW-1:0] w_a;
            logic [LW:0]   w_sum;
            logic [LW-1:0] w_res;

            assign w_a   = s_axis_tdata[l*LW +: LW];
            assign w_sum = {1'b0, w_a} + {1'b0, r_const};

            // Select the lane result; a carry out of the sum clamps the saturating add.
            always_comb begin
                w_res = w_a;
                case (r_mode)
                    3'd1:    w_res = w_sum[LW-1:0];
                    3'd2:    w_res = w_a - r_const;
                    3'd3:    w_res = w_sum[LW] ? {LW{1'b1}} : w_sum[LW-1:0];
                    3'd4:    w_res = w_a ^ r_const;
                    default: w_res = w_a;
                endcase
            end

            assign w_lane_res[l*LW +: LW] = w_res;
        end
    endgenerate

    // Pipeline registers: stage 1 captures the ALU result, later stages shift forward when allowed.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int k = 0; k < NS; k++) begin
                r_dat[k]  <= '0;
                r_keep[k] <= '0;
            end
        end else begin
            if (w_stage_rdy[0]) begin
                r_vld[0] <= w_in_acc;
                if (w_in_acc) begin
                    r_dat[0]  <= w_lane_res;
                    r_keep[0] <= s_axis_tkeep;
                    r_last[0] <= s_axis_tlast;
                end
            end
            for (int k = 1; k < NS; k++) begin
                if (w_stage_rdy[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_dat[k]  <= r_dat[k-1];
                        r_keep[k] <= r_keep[k-1];
                        r_last[k] <= r_last[k-1];
                    end
                end
            end
        end
    end

    // Transfer FSM next state: IDLE -> RUN on start, RUN -> DRAIN on input tlast, DRAIN -> IDLE on output tlast.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_in_acc && s_axis_tlast) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_out_acc && m_axis_tlast) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state and the one-cycle done pulse, which coincides with the return to IDLE.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Operation and constant are captured only on a start seen in IDLE; later starts are ignored.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_mode  <= 3'd0;
            r_const <= '0;
        end else if (w_start_acc) begin
            r_mode  <= ctrl_mode;
            r_const <= ctrl_constant;
        end
    end

    // Output beat counter: cleared on start, saturating, frozen while IDLE.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_beat_cnt <= 32'd0;
        end else if (w_start_acc) begin
            r_beat_cnt <= 32'd0;
        end else if ((r_state != ST_IDLE) && w_out_acc && (r_beat_cnt != 32'hFFFF_FFFF)) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

endmodule
